// File: rtl/blockram_arbiter.sv
// blockram_arbiter
//   Round-robin arbiter sharing one single-port iCE40 EBR between two
//   requesters (A, B). The winner's command is registered onto the RAM port,
//   sel_a drives the external 2:1 channel mux, and read data is routed back
//   with a per-requester rvalid pulse.
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x requester x command (held until gnt_x)
//   gnt_x                     one-cycle pulse: x's access is on the RAM port
//   rvalid_x                  one-cycle pulse: rdata holds x's read result
//   rdata                     shared read data (pass-through of ram_rdata)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   EBR port (registered read)
//   sel_a                     1 = port owned by A this cycle, 0 = B
module blockram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  sel_a
);

  logic last_a;   // 1 = A won the most recent arbitration, 0 = B
  logic elig_a;
  logic elig_b;
  logic win_a;
  logic win_b;

  // A requester granted this cycle still shows the command just served,
  // so it is masked for one edge.
  always_comb begin
    elig_a = req_a & ~gnt_a;
    elig_b = req_b & ~gnt_b;
    win_a  = elig_a & (~elig_b | ~last_a);
    win_b  = elig_b & ~win_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      sel_a     <= 1'b0;
      last_a    <= 1'b0;
    end else begin
      // The launch registers double as the 1-deep owner/read pipeline:
      // the EBR returns data one cycle after ram_en.
      rvalid_a <= gnt_a & ~ram_we;
      rvalid_b <= gnt_b & ~ram_we;
      gnt_a    <= win_a;
      gnt_b    <= win_b;
      ram_en   <= win_a | win_b;
      if (win_a) begin
        ram_we    <= we_a;
        ram_addr  <= addr_a;
        ram_wdata <= wdata_a;
        sel_a     <= 1'b1;
        last_a    <= 1'b1;
      end else if (win_b) begin
        ram_we    <= we_b;
        ram_addr  <= addr_b;
        ram_wdata <= wdata_b;
        sel_a     <= 1'b0;
        last_a    <= 1'b0;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

  assign rdata = ram_rdata;

endmodule

// File: tb/tb_blockram_arbiter.sv
// tb_blockram_arbiter
//   Self-checking bench for blockram_arbiter: behavioural EBR, reference
//   model of grants/port/rvalid/read data, directed scenarios then random
//   traffic.
module tb_blockram_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata;
  logic          ram_en, ram_we, sel_a;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  blockram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sel_a(sel_a)
  );

  always #5 clk = ~clk;

  // Behavioural EBR: registered read, write-enable gated by ram_en.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model state: what the DUT outputs should be in the current cycle.
  logic [DW-1:0] ref_mem [256];
  logic          e_gnt_a = 0, e_gnt_b = 0, e_en = 0, e_we = 0, e_sel_a = 0;
  logic          e_rv_a = 0, e_rv_b = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  int            prefer_a = 1;   // whose turn it is when both are eligible
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Inputs are already driven; advance the model to the next cycle, wait for
  // it, and compare the DUT against the model.
  task automatic tick();
    logic          nxt_rv_a, nxt_rv_b;
    logic [DW-1:0] nxt_rdata;
    logic          ea, eb;
    int            winner;   // 0 none, 1 A, 2 B
    nxt_rv_a  = e_en && e_gnt_a && !e_we;
    nxt_rv_b  = e_en && e_gnt_b && !e_we;
    nxt_rdata = ref_mem[e_addr];
    if (e_en && e_we) ref_mem[e_addr] = e_wdata;
    ea = req_a && !e_gnt_a;
    eb = req_b && !e_gnt_b;
    if (ea && eb) winner = prefer_a ? 1 : 2;
    else if (ea)  winner = 1;
    else if (eb)  winner = 2;
    else          winner = 0;
    if (rst) begin
      {e_gnt_a, e_gnt_b, e_en, e_we, e_sel_a, e_rv_a, e_rv_b} = '0;
      e_addr   = '0;
      e_wdata  = '0;
      prefer_a = 1;
    end else begin
      e_rv_a  = nxt_rv_a;
      e_rv_b  = nxt_rv_b;
      e_rdata = nxt_rdata;
      e_gnt_a = (winner == 1);
      e_gnt_b = (winner == 2);
      e_en    = (winner != 0);
      if (winner == 1) begin
        e_we = we_a; e_addr = addr_a; e_wdata = wdata_a; e_sel_a = 1'b1; prefer_a = 0;
      end else if (winner == 2) begin
        e_we = we_b; e_addr = addr_b; e_wdata = wdata_b; e_sel_a = 1'b0; prefer_a = 1;
      end else begin
        e_we = 1'b0;
      end
    end
    @(negedge clk);
    check("gnt_a", 32'(gnt_a), 32'(e_gnt_a));
    check("gnt_b", 32'(gnt_b), 32'(e_gnt_b));
    check("ram_en", 32'(ram_en), 32'(e_en));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    check("sel_a", 32'(sel_a), 32'(e_sel_a));
    check("rvalid_a", 32'(rvalid_a), 32'(e_rv_a));
    check("rvalid_b", 32'(rvalid_b), 32'(e_rv_b));
    if (e_rv_a || e_rv_b) check("rdata", 32'(rdata), 32'(e_rdata));
  endtask

  task automatic wait_gnt(input bit for_a);
    for (int n = 0; n < 8; n++) begin
      tick();
      if (for_a ? gnt_a : gnt_b) return;
    end
    check(for_a ? "gnt_a_timeout" : "gnt_b_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h1111);
      ref_mem[i] = 16'(i * 16'h1111);
    end

    // Reset held with both requesting; A must win the first tie.
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("first_grant", 32'({gnt_a, gnt_b}), 32'b10);
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();

    // Single write then read by A.
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'h10; wdata_a = 16'h5A5A;
    wait_gnt(1'b1);
    check("wr_we", 32'(ram_we), 32'd1);
    we_a = 1'b0;
    wait_gnt(1'b1);
    req_a = 1'b0;
    tick();
    check("rd_rvalid_a", 32'(rvalid_a), 32'd1);
    check("rd_data", 32'(rdata), 32'h5A5A);
    tick(); tick();

    // Contention: both held for 8 cycles -> strict alternation.
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h03;
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'h04;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("contend_one_gnt", 32'(gnt_a ^ gnt_b), 32'd1);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick(); tick();

    // Solo streaming by B: one grant every two cycles.
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'h07;
    for (int i = 0; i < 8; i++) tick();
    req_b = 1'b0;
    tick(); tick(); tick();

    // Mixed: A reads 0x01 while B writes 0x02.
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h01;
    req_b = 1'b1; we_b = 1'b1; addr_b = 8'h02; wdata_b = 16'hBEEF;
    for (int i = 0; i < 2; i++) tick();
    req_a = 1'b0; req_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mixed_no_rvalid_b", 32'(rvalid_b), 32'd0);
      if (rvalid_a) check("mixed_rdata", 32'(rdata), 32'h1111);
    end

    // Reset in the cycle after a read grant: response is dropped.
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h05;
    wait_gnt(1'b1);
    req_a = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_drop_rvalid", 32'(rvalid_a), 32'd0);
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    tick();
    check("rst_tie_to_a", 32'({gnt_a, gnt_b}), 32'b10);
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();

    // Random traffic obeying the requester rule, with occasional withdrawal.
    for (int c = 0; c < 600; c++) begin
      if (!(req_a && !gnt_a) || ($urandom_range(7) == 0)) begin
        req_a   = ($urandom_range(9) < 6);
        we_a    = $urandom_range(1);
        addr_a  = 8'($urandom_range(15));
        wdata_a = 16'($urandom);
      end
      if (!(req_b && !gnt_b) || ($urandom_range(7) == 0)) begin
        req_b   = ($urandom_range(9) < 6);
        we_b    = $urandom_range(1);
        addr_b  = 8'($urandom_range(15));
        wdata_b = 16'($urandom);
      end
      rst = ($urandom_range(199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
